// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only LCD controller.
// Holds the FSM state type, the power-up init ROM and the long-command rule.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam int INIT_LEN = 4;

  // 8-bit bus / 2 lines, display on, clear, entry mode increment
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  localparam logic [7:0] LCD_CLR  = 8'h01;
  localparam logic [7:0] LCD_HOME = 8'h02;

  // Clear and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CLR) || (data[7:1] == LCD_HOME[7:1]));
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter used for every phase duration of the LCD controller.
// o_done is high while the count reads zero; the counter never wraps.
module lcd_timer #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RST_VALUE = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= RST_VALUE;
    end else if (i_load) begin
      cnt_q <= i_value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: runs the power-up init sequence, then sends
// single command/data bytes accepted over a valid/ready handshake.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 25,
  parameter int T_HOLD_CYC  = 4,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_vld,
  input  logic       i_cmd_rs,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_rdy,
  output logic       o_busy,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic [7:0] o_lcd_data
);

  localparam int T_MAX = max2(max2(max2(T_PWRUP_CYC, T_SETUP_CYC), max2(T_EN_CYC, T_HOLD_CYC)),
                              max2(T_CMD_CYC, T_CLR_CYC));
  localparam int TW    = $clog2(T_MAX + 1);

  // Phase lengths as load values: a phase of N cycles starts the count at N-1.
  localparam logic [TW-1:0] LD_PWRUP = TW'(T_PWRUP_CYC - 1);
  localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP_CYC - 1);
  localparam logic [TW-1:0] LD_EN    = TW'(T_EN_CYC - 1);
  localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD_CYC - 1);
  localparam logic [TW-1:0] LD_CMD   = TW'(T_CMD_CYC - 1);
  localparam logic [TW-1:0] LD_CLR   = TW'(T_CLR_CYC - 1);

  lcd_state_e  state_q;
  logic [1:0]  init_idx_q;
  logic        rdy_q;
  logic        busy_q;
  logic        init_done_q;
  logic        lcd_on_q;
  logic        lcd_rs_q;
  logic        lcd_en_q;
  logic [7:0]  lcd_data_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;

  // The reset value covers the power-up wait so no load is needed to start it.
  lcd_timer #(
    .W         (TW),
    .RST_VALUE (LD_PWRUP)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (tmr_load),
    .i_value (tmr_value),
    .o_done  (tmr_done)
  );

  // Timer reload accompanies every state change into a timed phase.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_INIT_LOAD: begin
        tmr_load  = 1'b1;
        tmr_value = LD_SETUP;
      end
      ST_IDLE: begin
        tmr_load  = i_cmd_vld;
        tmr_value = LD_SETUP;
      end
      ST_SETUP: begin
        tmr_load  = tmr_done;
        tmr_value = LD_EN;
      end
      ST_PULSE: begin
        tmr_load  = tmr_done;
        tmr_value = LD_HOLD;
      end
      ST_HOLD: begin
        tmr_load  = tmr_done;
        tmr_value = is_long_cmd(lcd_rs_q, lcd_data_q) ? LD_CLR : LD_CMD;
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_PWRUP;
      init_idx_q  <= '0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      lcd_on_q    <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_data_q  <= '0;
    end else begin
      lcd_on_q <= 1'b1;
      case (state_q)
        ST_PWRUP: begin
          busy_q <= 1'b1;
          if (tmr_done) begin
            state_q <= ST_INIT_LOAD;
          end
        end
        ST_INIT_LOAD: begin
          lcd_rs_q   <= 1'b0;
          lcd_data_q <= INIT_ROM[init_idx_q];
          state_q    <= ST_SETUP;
        end
        ST_IDLE: begin
          if (i_cmd_vld) begin
            lcd_rs_q   <= i_cmd_rs;
            lcd_data_q <= i_cmd_data;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            lcd_en_q <= 1'b1;
            state_q  <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (tmr_done) begin
            lcd_en_q <= 1'b0;
            state_q  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tmr_done) begin
            if (!init_done_q && (init_idx_q != 2'(INIT_LEN - 1))) begin
              init_idx_q <= init_idx_q + 2'd1;
              state_q    <= ST_INIT_LOAD;
            end else begin
              init_done_q <= 1'b1;
              rdy_q       <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_PWRUP;
        end
      endcase
    end
  end

  assign o_cmd_rdy   = rdy_q;
  assign o_busy      = busy_q;
  assign o_init_done = init_done_q;
  assign o_lcd_on    = lcd_on_q;
  assign o_lcd_rs    = lcd_rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = lcd_en_q;
  assign o_lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed + randomized bench for lcd_ctrl; expected timing comes from
// phase-length arithmetic on the bench's own copy of the command rules.
module tb_lcd_ctrl;

  localparam int T_PWRUP = 20;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_vld = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       o_cmd_rdy, o_busy, o_init_done, o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en;
  logic [7:0] o_lcd_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_ctrl #(
    .T_PWRUP_CYC (T_PWRUP),
    .T_SETUP_CYC (T_SETUP),
    .T_EN_CYC    (T_EN),
    .T_HOLD_CYC  (T_HOLD),
    .T_CMD_CYC   (T_CMD),
    .T_CLR_CYC   (T_CLR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_vld   (cmd_vld),
    .i_cmd_rs    (cmd_rs),
    .i_cmd_data  (cmd_data),
    .o_cmd_rdy   (o_cmd_rdy),
    .o_busy      (o_busy),
    .o_init_done (o_init_done),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_data  (o_lcd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int twait(input logic rs, input logic [7:0] d);
    if (rs == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return T_CLR;
    return T_CMD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the edge that entered SETUP.
  task automatic run_txn(input string tag, input logic rs, input logic [7:0] d,
                         input int poke_at, input logic exp_rdy_end);
    int len = T_SETUP + T_EN + T_HOLD + twait(rs, d);
    int en_cnt = 0, en_first = -1, en_last = -1, bad_hold = 0, bad_rdy = 0;
    for (int c = 0; c < len; c++) begin
      if (c == poke_at) begin
        cmd_vld = 1'b1; cmd_rs = ~rs; cmd_data = ~d;
      end else if (poke_at >= 0 && c == poke_at + 1) begin
        cmd_vld = 1'b0;
      end
      if (o_lcd_en === 1'b1) begin
        en_cnt++;
        if (en_first < 0) en_first = c;
        en_last = c;
      end
      if (o_lcd_rs !== rs || o_lcd_data !== d) bad_hold++;
      if (o_cmd_rdy !== 1'b0 || o_busy !== 1'b1) bad_rdy++;
      @(negedge clk);
    end
    chk({tag, "_en_cycles"}, en_cnt, T_EN);
    chk({tag, "_en_first"}, en_first, T_SETUP);
    chk({tag, "_en_last"}, en_last, T_SETUP + T_EN - 1);
    chk({tag, "_hold"}, bad_hold, 0);
    chk({tag, "_busy_span"}, bad_rdy, 0);
    chk({tag, "_rdy_end"}, o_cmd_rdy, exp_rdy_end);
    $display("txn %s rs=%0d data=%02h cycles=%0d en=%0d", tag, rs, d, len, en_cnt);
  endtask

  // Called at the negedge after the first edge following reset release.
  task automatic run_init(input string tag);
    chk({tag, "_lcd_on"}, o_lcd_on, 1);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_rdy"}, o_cmd_rdy, 0);
    repeat (T_PWRUP) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk({tag, $sformatf("_done_pre%0d", i)}, o_init_done, 0);
      run_txn($sformatf("%s_rom%0d", tag, i), 1'b0, init_bytes[i], -1, (i == 3));
      if (i < 3) @(negedge clk);
    end
    chk({tag, "_init_done"}, o_init_done, 1);
    chk({tag, "_busy_idle"}, o_busy, 0);
  endtask

  // Presents a request and returns at the negedge after its accept edge.
  task automatic present(input string tag, input logic rs, input logic [7:0] d);
    int w = 0;
    cmd_vld = 1'b1; cmd_rs = rs; cmd_data = d;
    while (o_cmd_rdy !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_rdy_seen"}, o_cmd_rdy, 1);
    @(negedge clk);
  endtask

  task automatic send(input string tag, input logic rs, input logic [7:0] d, input int poke_at);
    present(tag, rs, d);
    cmd_vld = 1'b0;
    run_txn(tag, rs, d, poke_at, 1'b1);
  endtask

  initial begin
    logic [7:0] d;
    logic       rs;
    int         en_seen;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_on", o_lcd_on, 0);
    chk("rst_en", o_lcd_en, 0);
    chk("rst_rdy", o_cmd_rdy, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_init_done, 0);
    chk("rst_data", {o_lcd_rs, o_lcd_data}, 0);
    chk("rw_const", o_lcd_rw, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_init("init");

    send("data41", 1'b1, 8'h41, -1);
    send("clr_cmd", 1'b0, 8'h01, -1);
    send("clr_data", 1'b1, 8'h01, -1);
    send("home3", 1'b0, 8'h03, -1);

    // vld held across three transactions
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom_range(8'h20, 8'h7E));
      cmd_vld = 1'b1; cmd_rs = 1'b1; cmd_data = d;
      if (k == 0) present("b2b0", 1'b1, d);
      else @(negedge clk);
      run_txn($sformatf("b2b%0d", k), 1'b1, d, -1, 1'b1);
    end
    cmd_vld = 1'b0;
    en_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_lcd_en === 1'b1 || o_cmd_rdy !== 1'b1) en_seen++;
    end
    chk("b2b_quiet", en_seen, 0);

    send("poke", 1'b1, 8'h5A, 5);
    en_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_lcd_en === 1'b1 || o_cmd_rdy !== 1'b1 || o_lcd_data !== 8'h5A) en_seen++;
    end
    chk("poke_ignored", en_seen, 0);

    for (int k = 0; k < 6; k++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      send($sformatf("rand%0d", k), rs, d, -1);
    end

    // reset in the middle of the EN pulse
    present("rstmid", 1'b1, 8'h77);
    cmd_vld = 1'b0;
    repeat (T_SETUP + 1) @(negedge clk);
    chk("rstmid_en_before", o_lcd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_en", o_lcd_en, 0);
    chk("rstmid_on", o_lcd_on, 0);
    chk("rstmid_rdy", o_cmd_rdy, 0);
    chk("rstmid_done", o_init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_init("reinit");
    send("post_reset", 1'b1, 8'h42, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
